// File: rtl/kamacore_fetch_unit.sv
// Instruction fetch stage: sequential word fetch, prefetch queue, branch redirect, decode backpressure.
// Optional performance counters are enabled by defining KAMACORE_FETCH_PERF_EN.
module kamacore_fetch_unit #(
  parameter int CPU_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0]  imem_rdata,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [CPU_WIDTH-1:0]  id_instruction,
  output logic [ADDR_WIDTH-1:0] id_pc
`ifdef KAMACORE_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushes
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_reg;
  logic [ADDR_WIDTH-1:0] inflight_pc_reg;
  logic                  inflight_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [PTR_W-1:0]      head_reg;
  logic [PTR_W-1:0]      tail_reg;
  logic [CPU_WIDTH-1:0]  q_instr_reg [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_reg    [DEPTH];
  logic [CNT_W:0]        occupancy;
  logic                  push;
  logic                  pop;

  // Credit check counts the in-flight request so the queue can never overflow.
  always_comb begin
    occupancy      = {1'b0, count_reg} + (CNT_W+1)'(inflight_reg);
    imem_req       = !rst && !branch_valid && (occupancy < (CNT_W+1)'(DEPTH));
    imem_addr      = fetch_pc_reg;
    id_valid       = (count_reg != '0);
    push           = inflight_reg && !branch_valid;
    pop            = id_valid && id_ready && !branch_valid;
    id_instruction = id_valid ? q_instr_reg[head_reg] : '0;
    id_pc          = id_valid ? q_pc_reg[head_reg] : '0;
    count_next     = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= ADDR_WIDTH'(RESET_PC);
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      count_reg       <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
    end else if (branch_valid) begin
      // Redirect flushes the queue and kills the response arriving this cycle.
      fetch_pc_reg <= branch_target;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc_reg    <= fetch_pc_reg + ADDR_WIDTH'(1);
        inflight_pc_reg <= fetch_pc_reg;
      end
      inflight_reg <= imem_req;
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_instr_reg[tail_reg] <= imem_rdata;
      q_pc_reg[tail_reg]    <= inflight_pc_reg;
    end
  end

`ifdef KAMACORE_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (id_valid && id_ready) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (branch_valid) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kamacore_fetch_unit.sv
// Directed self-checking bench for kamacore_fetch_unit; imem holds 0x1000+address at every address.
module tb_kamacore_fetch_unit;
  localparam int AW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [CW-1:0] imem_rdata;
  logic          id_valid;
  logic          id_ready;
  logic [CW-1:0] id_instruction;
  logic [AW-1:0] id_pc;
`ifdef KAMACORE_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushes;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  kamacore_fetch_unit #(
    .CPU_WIDTH(CW), .ADDR_WIDTH(AW), .DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instruction(id_instruction), .id_pc(id_pc)
`ifdef KAMACORE_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle-latency instruction memory.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'h1000 + {16'h0, imem_addr};
  end

  always @(negedge clk) begin
    if (!rst && !branch_valid && id_valid && id_ready)
      $display("xfer pc=%h instr=%h", id_pc, id_instruction);
  end

  function automatic logic [CW-1:0] word_at(input logic [AW-1:0] a);
    return 32'h1000 + {16'h0, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; branch_valid = 1'b0; branch_target = '0; id_ready = ready;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; branch_valid = 1'b0; branch_target = '0; id_ready = 1'b1;
    step(); step();
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_instruction !== '0) begin n_fail++; $display("FAIL reset_id_instruction: got %h expected 0", id_instruction); end
    n_checks++; if (id_pc !== '0) begin n_fail++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    step();
  endtask

  task automatic test_sequential();
    logic [AW-1:0] exp_pc;
    rst = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
          n_fail++; $display("FAIL seq_first_issue: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
        end
      end
      if (c < 2) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_latency c=%0d: got id_valid=%b expected 0", c, id_valid); end
      end else begin
        exp_pc = AW'(c - 2);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instruction !== word_at(exp_pc)) begin
          n_fail++; $display("FAIL seq_deliver c=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                             c, id_valid, id_pc, id_instruction, exp_pc, word_at(exp_pc));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    logic [AW-1:0] exp_pc;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) reqs++;
      step();
    end
    n_checks++; if (reqs != 4) begin n_fail++; $display("FAIL bp_request_count: got %0d expected 4", reqs); end
    id_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if (r == 0) begin
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold: got imem_req=%b expected 0", imem_req); end
      end
      exp_pc = AW'(r);
      n_checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instruction !== word_at(exp_pc)) begin
        n_fail++; $display("FAIL bp_release r=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                           r, id_valid, id_pc, id_instruction, exp_pc, word_at(exp_pc));
      end
      step();
    end
  endtask

  // Redirect issued at the current cycle; checks flush, latency and delivered PCs from base.
  task automatic check_after_redirect(input string name, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] exp_pc;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c < 3) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL %s_flush c=%0d: got id_valid=%b expected 0", name, c, id_valid); end
      end else begin
        exp_pc = base + AW'(c - 3);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instruction !== word_at(exp_pc)) begin
          n_fail++; $display("FAIL %s_deliver c=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                             name, c, id_valid, id_pc, id_instruction, exp_pc, word_at(exp_pc));
        end
      end
      step();
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    repeat (8) step();
    branch_valid = 1'b1; branch_target = 16'h0040;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: got imem_req=%b expected 0", imem_req); end
    step();
    branch_valid = 1'b0; id_ready = 1'b1;
    check_after_redirect("redir_full", 16'h0040, 8);
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    repeat (5) step();
    branch_valid = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_valid = 1'b0;
    check_after_redirect("wrap", 16'hFFFF, 6);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (4) step();
    branch_valid = 1'b1; branch_target = 16'h0020;
    step();
    branch_target = 16'h0080;
    step();
    branch_valid = 1'b0;
    check_after_redirect("b2b", 16'h0080, 6);
  endtask

  task automatic test_reset_midstream();
    logic [AW-1:0] exp_pc;
    do_reset(1'b0);
    repeat (4) step();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_precondition: got v=%b req=%b expected v=1 req=0", id_valid, imem_req);
    end
    rst = 1'b1; id_ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_pc !== '0 || id_instruction !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got v=%b req=%b pc=%h ins=%h expected all 0",
                         id_valid, imem_req, id_pc, id_instruction);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 2) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_latency c=%0d: got id_valid=%b expected 0", c, id_valid); end
      end else begin
        exp_pc = AW'(c - 2);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instruction !== word_at(exp_pc)) begin
          n_fail++; $display("FAIL mid_restart c=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                             c, id_valid, id_pc, id_instruction, exp_pc, word_at(exp_pc));
        end
      end
      step();
    end
  endtask

`ifdef KAMACORE_FETCH_PERF_EN
  task automatic test_perf();
    do_reset(1'b0);
    @(negedge clk);
    n_checks++; if (perf_fetched !== 32'd0 || perf_flushes !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got fetched=%0d flushes=%0d expected 0 0", perf_fetched, perf_flushes);
    end
    step();
    repeat (6) step();
    id_ready = 1'b1;
    repeat (5) step();
    id_ready = 1'b0; branch_valid = 1'b1; branch_target = 16'h0010;
    step(); step();
    branch_valid = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if (perf_fetched !== 32'd5 || perf_flushes !== 32'd2) begin
      n_fail++; $display("FAIL perf_counts: got fetched=%0d flushes=%0d expected 5 2", perf_fetched, perf_flushes);
    end
    rst = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (perf_fetched !== 32'd0 || perf_flushes !== 32'd0) begin
      n_fail++; $display("FAIL perf_clear: got fetched=%0d flushes=%0d expected 0 0", perf_fetched, perf_flushes);
    end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; branch_valid = 1'b0; branch_target = '0; id_ready = 1'b0;
    step();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
`ifdef KAMACORE_FETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
